timer_mc: RTL and testbench
===========================

// Module: timer_mc
// PURPOSE
//  Multi-channel programmable down-counter timer. Generalised successor of the single 16-bit timer.
//  Sits on the 8-bit CPU peripheral bus behind one chip select and drives one interrupt line.
//  Each channel has: reload register, live counter, one-shot/periodic mode, per-channel IRQ enable, W1C flag.
// PARAMETERS
//  WIDTH     16  counter width in bits; multiple of 8, range 8..32
//  CHANNELS  2   number of independent channels, 1..8
//  AW        $clog2(CHANNELS)+3  address width, derived (local)
// PORTS
//  clk    in   1      system clock, all state on posedge
//  rst_n  in   1      asynchronous active-low reset
//  AD     in   AW     register address: AD[AW-1:3] = channel, AD[2:0] = offset
//  DI     in   8      write data
//  DO     out  8      read data, combinational from AD
//  rw     in   1      1 = read, 0 = write
//  cs     in   1      chip select; write commits on posedge when cs && ~rw
//  intr   out  1      registered OR over channels of (flag & ie)
// BEHAVIOUR
//  Offsets per channel:
//   0..3 CNT bytes; 4 CTRL; 5 STAT; 6 PRESC; 7 reserved (reads 0).
//   CNT bytes >= WIDTH/8 read 0; writes ignored.
//  CNT write: updates byte of RELOAD only; a running count is unaffected until next load.
//  CNT read: offset 0 returns live counter[7:0].
//   A read access to offset 0 snapshots counter[WIDTH-1:8] into SHADOW on that posedge.
//   Offsets 1..3 return SHADOW, giving atomic multi-byte reads.
//  CTRL: bit0 EN, bit1 PER (1 = periodic), bit2 IE; bits 7:3 read 0.
//   Write with EN 0->1: counter <= RELOAD, prescaler cleared, state RUN.
//   Write with EN=0: state IDLE, counter holds.
//   Write with EN 1->1: mode/IE bits update only; no reload.
//  STAT: bit0 FLAG (write 1 clears, write 0 no effect); bit1 RUN (read-only).
//  Per-channel FSM IDLE<->RUN; tick = every clk (or prescaled tick, see CONFIGURATION).
//   In RUN on tick: if counter != 1, counter <= counter-1 (mod 2^WIDTH).
//   If counter == 1: FLAG <= 1. PER=1: counter <= RELOAD, stay RUN.
//   If counter == 1 and PER=0: counter <= 0, EN <= 0, state IDLE.
//  RELOAD = 0: period 2^WIDTH ticks (0 wraps to all-ones). RELOAD = 1: expiry every tick.
//  Simultaneous expiry and FLAG W1C in same cycle: set wins, FLAG = 1.
//  Simultaneous expiry and CTRL write EN=0: write wins, IDLE; FLAG still set.
//  intr is 1 clk after FLAG&IE; it drops 1 clk after the clear.
//  Reset (async, any time incl. mid-count): all RELOAD, counter, SHADOW, CTRL, FLAG, PRESC = 0.
//   After reset: state IDLE, intr = 0, DO reads 0 for every address.
// CONFIGURATION
//  TIMER_MC_PRESCALER_EN defined:
//   Offset 6 is an 8-bit R/W PRESC per channel; tick fires every PRESC+1 clks in RUN.
//   The 8-bit prescale counter restarts at EN 0->1 and at each expiry.
//   PRESC writes take effect at the next prescaler wrap.
//  Undefined: tick = every clk in RUN; offset 6 reads 0, writes ignored; no prescaler flops.
// STRUCTURE
//  Package timer_mc_pkg:
//   Offset constants OFS_CNT0..OFS_CNT3, OFS_CTRL, OFS_STAT, OFS_PRESC.
//   CTRL bit indices CTRL_EN, CTRL_PER, CTRL_IE; STAT bit indices STAT_FLAG, STAT_RUN.
//  Sub-module timer_mc_channel (one per channel, generate loop):
//   Holds RELOAD, counter, SHADOW, CTRL, FLAG and prescaler.
//   Inputs: decoded wr strobe, rd0 strobe, offset, DI. Outputs: read byte, irq.
//  Top level holds only channel decode, the DO mux and the intr register.
// TESTING
//  1. RELOAD=0x0003, CTRL=0x05 (one-shot, IE): FLAG and intr set 3 ticks later (intr +1 clk).
//     Then counter=0, EN=0, STAT=0x01.
//  2. RELOAD=0x0002, CTRL=0x07 periodic: FLAG sets every 2 clks.
//     W1C STAT in the expiry cycle -> FLAG stays 1; W1C elsewhere -> 0, intr drops next clk.
//  3. Running ch0 at 0x1234: read offset 0 returns 0x34 and latches 0x12.
//     Read offset 1 ten clks later returns 0x12.
//  4. ch1 periodic 5, ch0 one-shot 9, IE on both:
//     FLAGs independent; intr stays high until both flags are cleared.
//  5. Deassert rst_n mid-count (async, between edges):
//     all regs, DO and intr are 0 immediately; no tick after release until CTRL EN written.
//  6. TIMER_MC_PRESCALER_EN defined, PRESC=3, RELOAD=2: expiry at 8 clks.
//     Macro undefined: expiry at 2 clks and offset 6 reads 0.

Source files
------------

// File: rtl/timer_mc_pkg.sv
// Shared constants for the multi-channel timer: register offsets, bit indices, channel FSM states.
package timer_mc_pkg;

    localparam logic [2:0] OFS_CNT0  = 3'd0;
    localparam logic [2:0] OFS_CNT1  = 3'd1;
    localparam logic [2:0] OFS_CNT2  = 3'd2;
    localparam logic [2:0] OFS_CNT3  = 3'd3;
    localparam logic [2:0] OFS_CTRL  = 3'd4;
    localparam logic [2:0] OFS_STAT  = 3'd5;
    localparam logic [2:0] OFS_PRESC = 3'd6;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_PER  = 1;
    localparam int CTRL_IE   = 2;
    localparam int STAT_FLAG = 0;
    localparam int STAT_RUN  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

endpackage

// File: rtl/timer_mc_channel.sv
// One timer channel: reload/counter/shadow registers, control bits, W1C flag and IDLE/RUN FSM.
// Optional per-channel prescaler when TIMER_MC_PRESCALER_EN is defined.
module timer_mc_channel #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic       rd0,
    input  logic [2:0] ofs,
    input  logic [7:0] di,
    output logic [7:0] rdata,
    output logic       irq
);
    import timer_mc_pkg::*;

    localparam int NB = WIDTH / 8;
    localparam int SW = (WIDTH > 8) ? WIDTH - 8 : 1;

    logic [WIDTH-1:0] reload_q, reload_d, cnt_q, cnt_d;
    logic [SW-1:0]    shadow_q, shadow_d;
    logic             en_q, en_d, per_q, per_d, ie_q, ie_d, flag_q, flag_d;
    chan_state_e      state_q, state_d;
    logic             tick;
    logic [23:0]      sh_ext;

`ifdef TIMER_MC_PRESCALER_EN
    logic [7:0] presc_q, presc_d, psc_cnt_q, psc_cnt_d, psc_lim_q, psc_lim_d;
    // psc_lim holds the divider in force; new PRESC values are adopted only at a wrap
    assign tick = (state_q == ST_RUN) && (psc_cnt_q == psc_lim_q);
`else
    assign tick = (state_q == ST_RUN);
`endif

    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        en_d     = en_q;
        per_d    = per_q;
        ie_d     = ie_q;
        flag_d   = flag_q;
        state_d  = state_q;
`ifdef TIMER_MC_PRESCALER_EN
        presc_d   = presc_q;
        psc_cnt_d = psc_cnt_q;
        psc_lim_d = psc_lim_q;
        if (state_q == ST_RUN) begin
            psc_cnt_d = tick ? 8'd0 : psc_cnt_q + 8'd1;
            if (tick) psc_lim_d = presc_q;
        end
`endif
        if (rd0) shadow_d = SW'(cnt_q >> 8);
        // clear is applied before expiry so a same-cycle expiry keeps FLAG set
        if (wr && ofs == OFS_STAT && di[STAT_FLAG]) flag_d = 1'b0;
        if (tick) begin
            if (cnt_q != WIDTH'(1)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else begin
                flag_d = 1'b1;
                if (per_q) begin
                    cnt_d = reload_q;
                end else begin
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        end
        if (wr) begin
            case (ofs)
                OFS_CNT0, OFS_CNT1, OFS_CNT2, OFS_CNT3: begin
                    for (int b = 0; b < NB; b++)
                        if (ofs == 3'(b)) reload_d[8*b +: 8] = di;
                end
                OFS_CTRL: begin
                    per_d = di[CTRL_PER];
                    ie_d  = di[CTRL_IE];
                    if (di[CTRL_EN] && !en_q) begin
                        en_d    = 1'b1;
                        cnt_d   = reload_q;
                        state_d = ST_RUN;
`ifdef TIMER_MC_PRESCALER_EN
                        psc_cnt_d = 8'd0;
                        psc_lim_d = presc_q;
`endif
                    end else if (!di[CTRL_EN]) begin
                        en_d    = 1'b0;
                        cnt_d   = cnt_q;
                        state_d = ST_IDLE;
                    end
                end
`ifdef TIMER_MC_PRESCALER_EN
                OFS_PRESC: presc_d = di;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            en_q     <= 1'b0;
            per_q    <= 1'b0;
            ie_q     <= 1'b0;
            flag_q   <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            per_q    <= per_d;
            ie_q     <= ie_d;
            flag_q   <= flag_d;
            state_q  <= state_d;
        end
    end

`ifdef TIMER_MC_PRESCALER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= 8'd0;
            psc_cnt_q <= 8'd0;
            psc_lim_q <= 8'd0;
        end else begin
            presc_q   <= presc_d;
            psc_cnt_q <= psc_cnt_d;
            psc_lim_q <= psc_lim_d;
        end
    end
`endif

    assign sh_ext = 24'(shadow_q);

    always_comb begin
        rdata = 8'd0;
        case (ofs)
            OFS_CNT0: rdata = cnt_q[7:0];
            OFS_CNT1: rdata = (NB > 1) ? sh_ext[7:0]   : 8'd0;
            OFS_CNT2: rdata = (NB > 2) ? sh_ext[15:8]  : 8'd0;
            OFS_CNT3: rdata = (NB > 3) ? sh_ext[23:16] : 8'd0;
            OFS_CTRL: rdata = {5'd0, ie_q, per_q, en_q};
            OFS_STAT: rdata = {6'd0, state_q == ST_RUN, flag_q};
`ifdef TIMER_MC_PRESCALER_EN
            OFS_PRESC: rdata = presc_q;
`endif
            default:  rdata = 8'd0;
        endcase
    end

    assign irq = flag_q & ie_q;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel down-counter timer on an 8-bit peripheral bus: channel decode, read mux, intr register.
// Define TIMER_MC_PRESCALER_EN to enable the per-channel 8-bit prescaler at offset 6.
module timer_mc #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 2,
    localparam int AW       = $clog2(CHANNELS) + 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] AD,
    input  logic [7:0]    DI,
    output logic [7:0]    DO,
    input  logic          rw,
    input  logic          cs,
    output logic          intr
);
    import timer_mc_pkg::*;

    logic [AW-1:0]       ch_sel;
    logic [CHANNELS-1:0] ch_hit;
    logic [CHANNELS-1:0] ch_irq;
    logic [7:0]          ch_rdata [CHANNELS];
    logic                intr_q, intr_d;

    assign ch_sel = AD >> 3;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign ch_hit[gi] = (ch_sel == AW'(gi));
            timer_mc_channel #(.WIDTH(WIDTH)) u_ch (
                .clk   (clk),
                .rst_n (rst_n),
                .wr    (cs && !rw && ch_hit[gi]),
                .rd0   (cs && rw && ch_hit[gi] && AD[2:0] == OFS_CNT0),
                .ofs   (AD[2:0]),
                .di    (DI),
                .rdata (ch_rdata[gi]),
                .irq   (ch_irq[gi])
            );
        end
    endgenerate

    // unmapped channel numbers read as zero
    always_comb begin
        DO = 8'd0;
        for (int c = 0; c < CHANNELS; c++)
            if (ch_hit[c]) DO = ch_rdata[c];
    end

    assign intr_d = |ch_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) intr_q <= 1'b0;
        else        intr_q <= intr_d;
    end

    assign intr = intr_q;

endmodule

// File: tb/tb_timer_mc.sv
// Directed bench for timer_mc: stimulus queues expected values, an event-driven monitor checks them.
module tb_timer_mc;
    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;
    localparam int AW       = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] ad = '0;
    logic [7:0]    di = 8'd0;
    logic [7:0]    dout;
    logic          rw = 1'b1;
    logic          cs = 1'b0;
    logic          intr;

    typedef struct {
        string      name;
        bit         is_intr;
        logic [7:0] exp;
    } chk_t;

    chk_t sb[$];
    event chk_ev;
    int   total = 0;
    int   bad = 0;

    always #10 clk = ~clk;

    timer_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .AD    (ad),
        .DI    (di),
        .DO    (dout),
        .rw    (rw),
        .cs    (cs),
        .intr  (intr)
    );

    always @(chk_ev) begin : monitor
        chk_t       c;
        logic [7:0] got;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            got = c.is_intr ? {7'd0, intr} : dout;
            total++;
            if (got !== c.exp) begin
                bad++;
                $display("FAIL %s: got %02h expected %02h", c.name, got, c.exp);
            end else begin
                $display("ok   %s: %02h", c.name, got);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        ad = a; di = d; rw = 1'b0; cs = 1'b1;
        step(1);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic exp_do(input logic [AW-1:0] a, input logic [7:0] e, input string n);
        ad = a;
        #1;
        sb.push_back('{name: n, is_intr: 1'b0, exp: e});
        ->chk_ev;
        #1;
    endtask

    task automatic exp_intr(input logic e, input string n);
        #1;
        sb.push_back('{name: n, is_intr: 1'b1, exp: {7'd0, e}});
        ->chk_ev;
        #1;
    endtask

    task automatic rd_cs(input logic [AW-1:0] a, input logic [7:0] e, input string n);
        cs = 1'b1; rw = 1'b1;
        exp_do(a, e, n);
        step(1);
        cs = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        for (int a = 0; a < 16; a++) exp_do(AW'(a), 8'h00, "rst_do");
        exp_intr(1'b0, "rst_intr");
        rst_n = 1'b1;
        step(1);

        // one-shot, RELOAD=3, IE
        wr(4'd1, 8'h00);
        wr(4'd0, 8'h03);
        wr(4'd4, 8'h05);
        exp_do(4'd0, 8'h03, "t1_cnt3");
        step(1);
        exp_do(4'd0, 8'h02, "t1_cnt2");
        step(1);
        exp_do(4'd0, 8'h01, "t1_cnt1");
        exp_do(4'd5, 8'h02, "t1_stat_run");
        step(1);
        exp_do(4'd0, 8'h00, "t1_cnt_end");
        exp_do(4'd5, 8'h01, "t1_stat_flag");
        exp_do(4'd4, 8'h04, "t1_ctrl_en_off");
        exp_intr(1'b0, "t1_intr_lag");
        step(1);
        exp_intr(1'b1, "t1_intr_set");
        wr(4'd5, 8'h01);
        exp_do(4'd5, 8'h00, "t1_w1c");
        exp_intr(1'b1, "t1_intr_hold");
        step(1);
        exp_intr(1'b0, "t1_intr_drop");

        // periodic, RELOAD=2, W1C collision and plain clear
        wr(4'd0, 8'h02);
        wr(4'd4, 8'h07);
        exp_do(4'd0, 8'h02, "t2_cnt_load");
        step(1);
        exp_do(4'd5, 8'h02, "t2_stat_run");
        wr(4'd5, 8'h01);
        exp_do(4'd5, 8'h03, "t2_w1c_collide");
        exp_do(4'd0, 8'h02, "t2_reload");
        wr(4'd5, 8'h01);
        exp_do(4'd5, 8'h02, "t2_w1c_clear");
        exp_intr(1'b1, "t2_intr_before_drop");
        step(1);
        exp_intr(1'b0, "t2_intr_drop");
        exp_do(4'd5, 8'h03, "t2_flag_again");
        wr(4'd4, 8'h04);
        exp_do(4'd5, 8'h01, "t2_stopped");
        exp_do(4'd0, 8'h02, "t2_cnt_hold");
        wr(4'd5, 8'h01);
        step(2);
        exp_intr(1'b0, "t2_intr_idle");

        // atomic multi-byte read
        wr(4'd0, 8'h35);
        wr(4'd1, 8'h12);
        wr(4'd4, 8'h01);
        step(1);
        rd_cs(4'd0, 8'h34, "t3_lo");
        step(9);
        exp_do(4'd1, 8'h12, "t3_shadow");
        exp_do(4'd0, 8'h2a, "t3_lo_live");
        exp_do(4'd2, 8'h00, "t3_cnt2_zero");
        exp_do(4'd3, 8'h00, "t3_cnt3_zero");
        exp_do(4'd7, 8'h00, "t3_rsvd");
        wr(4'd4, 8'h00);

        // two independent channels
        wr(4'd0, 8'h09);
        wr(4'd1, 8'h00);
        wr(4'd8, 8'h05);
        wr(4'd4, 8'h05);
        wr(4'd12, 8'h07);
        step(4);
        exp_do(4'd0, 8'h04, "t4_ch0_cnt");
        exp_do(4'd13, 8'h02, "t4_ch1_run");
        exp_intr(1'b0, "t4_intr_low");
        step(1);
        exp_do(4'd13, 8'h03, "t4_ch1_flag");
        exp_do(4'd8, 8'h05, "t4_ch1_reload");
        exp_do(4'd5, 8'h02, "t4_ch0_noflag");
        step(1);
        exp_intr(1'b1, "t4_intr_ch1");
        step(2);
        exp_do(4'd5, 8'h01, "t4_ch0_flag");
        exp_do(4'd13, 8'h03, "t4_ch1_still");
        wr(4'd12, 8'h04);
        exp_do(4'd13, 8'h01, "t4_ch1_stop");
        exp_do(4'd8, 8'h02, "t4_ch1_hold");
        wr(4'd13, 8'h01);
        exp_do(4'd13, 8'h00, "t4_ch1_clear");
        step(1);
        exp_intr(1'b1, "t4_intr_ch0_only");
        wr(4'd5, 8'h01);
        exp_do(4'd5, 8'h00, "t4_ch0_clear");
        exp_intr(1'b1, "t4_intr_lag");
        step(1);
        exp_intr(1'b0, "t4_intr_both_clear");

        // asynchronous reset mid-count
        wr(4'd0, 8'h02);
        wr(4'd4, 8'h07);
        wr(4'd12, 8'h04);
        step(4);
        exp_intr(1'b1, "t5_intr_pre");
        exp_do(4'd4, 8'h07, "t5_ctrl_pre");
        #2 rst_n = 1'b0;
        exp_intr(1'b0, "t5_intr_async");
        exp_do(4'd4, 8'h00, "t5_ctrl_async");
        exp_do(4'd0, 8'h00, "t5_cnt_async");
        exp_do(4'd12, 8'h00, "t5_ch1_ctrl_async");
        step(2);
        #3 rst_n = 1'b1;
        step(5);
        exp_do(4'd0, 8'h00, "t5_no_tick");
        exp_do(4'd5, 8'h00, "t5_idle");
        exp_intr(1'b0, "t5_intr_idle");
        wr(4'd4, 8'h01);
        step(1);
        rd_cs(4'd0, 8'hff, "t5_reload0_wrap");
        exp_do(4'd1, 8'hff, "t5_wrap_hi");
        wr(4'd4, 8'h00);

        // prescaler
        wr(4'd6, 8'h03);
        wr(4'd0, 8'h02);
`ifdef TIMER_MC_PRESCALER_EN
        exp_do(4'd6, 8'h03, "t6_presc_rd");
        wr(4'd4, 8'h01);
        step(6);
        exp_do(4'd0, 8'h01, "t6_cnt_after_tick");
        step(1);
        exp_do(4'd5, 8'h02, "t6_not_yet");
        step(1);
        exp_do(4'd5, 8'h01, "t6_expire_8");
`else
        exp_do(4'd6, 8'h00, "t6_presc_absent");
        wr(4'd4, 8'h01);
        step(1);
        exp_do(4'd5, 8'h02, "t6_not_yet");
        exp_do(4'd0, 8'h01, "t6_cnt1");
        step(1);
        exp_do(4'd5, 8'h01, "t6_expire_2");
`endif
        step(2);
        if (total == 0) begin
            bad++;
            $display("FAIL monitor: no checks were executed");
        end
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d entries left unchecked", sb.size());
        end
        if (bad != 0) $display("FAIL summary: %0d of %0d checks failed", bad, total);
        else          $display("PASS summary: all %0d checks passed", total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
